// File: rtl/rr_packet_arbiter_pkg.sv
// Shared NoC definitions for the round-robin packet arbiter.
// Holds the arbiter state encoding.
package rr_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_packet_arbiter_onehot_enc.sv
// One-hot to binary index encoder (LSB0 or MSB0 numbering).
// Ports: onehot (NUM_SIGNALS) in, index (INDEX_WIDTH) out; zero in -> 0.
module rr_packet_arbiter_onehot_enc #(
  parameter int NUM_SIGNALS = 4,
  parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS),
  parameter     DIRECTION   = "LSB0"
) (
  input  logic [NUM_SIGNALS-1:0] onehot,
  output logic [INDEX_WIDTH-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (onehot[i]) begin
        if (DIRECTION == "LSB0") begin
          index = index | INDEX_WIDTH'(i);
        end else begin
          index = index | INDEX_WIDTH'(NUM_SIGNALS - 1 - i);
        end
      end
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-locked round-robin arbiter: grant held until the tail flit moves.
// Ports: clk, reset_n, request, request_tail, downstream_ready in;
//        grant_oh, grant_valid, grant_idx out.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [NUM_REQUESTERS-1:0] request_tail,
  input  logic                      downstream_ready,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic                      grant_valid,
  output logic [INDEX_WIDTH-1:0]    grant_idx
);

  arb_state_t                state_q, state_d;
  logic [INDEX_WIDTH-1:0]    ptr_q, ptr_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] pick;
  logic [INDEX_WIDTH-1:0]    pos;
  logic                      found;
  logic                      xfer;
  logic                      tail_hit;

  rr_packet_arbiter_onehot_enc #(
    .NUM_SIGNALS (NUM_REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH),
    .DIRECTION   ("LSB0")
  ) u_enc (
    .onehot (grant_q),
    .index  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Scan starts at ptr and wraps; first set request wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      pos = INDEX_WIDTH'((int'(ptr_q) + i) % NUM_REQUESTERS);
      if (!found && request[pos]) begin
        pick[pos] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Only the granted port's request/tail bits matter.
  assign xfer     = downstream_ready & |(grant_q & request);
  assign tail_hit = |(grant_q & request_tail);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (xfer && tail_hit) begin
          grant_d = '0;
          state_d = ST_IDLE;
          if (int'(grant_idx) == NUM_REQUESTERS - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant_oh    = grant_q;
    grant_valid = |grant_q;
  end

endmodule

// File: doc/rr_packet_arbiter.md
RR_PACKET_ARBITER -- requirements
Module: rr_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of competing input ports.
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(NUM_REQUESTERS), width of the binary grant index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port request  input  NUM_REQUESTERS  per-port flit-valid.
REQ-006 SHALL have port request_tail  input  NUM_REQUESTERS  per-port marker: the current flit is the packet's last.
REQ-007 SHALL have port downstream_ready  input  1  consumer accepts a flit this cycle.
REQ-008 SHALL have port grant_oh  output  NUM_REQUESTERS  registered one-hot grant; bit i = port i.
REQ-009 SHALL have port grant_valid  output  1  high when grant_oh is nonzero.
REQ-010 SHALL have port grant_idx  output  INDEX_WIDTH  binary index of the grant_oh bit, LSB0.

Function
REQ-011 SHALL implement two states: IDLE (no grant) and LOCKED (one grant held).
REQ-012 SHALL keep a priority pointer ptr in range 0..NUM_REQUESTERS-1; the highest-priority port is ptr.
REQ-013 In IDLE with any request bit set, SHALL select the first set bit scanning ptr, ptr+1, ... with mod-NUM_REQUESTERS wrap.
REQ-014 SHALL register that winner into grant_oh and enter LOCKED at the next edge (one-cycle arbitration latency).
REQ-015 In IDLE with request all zero, SHALL remain in IDLE with grant_oh=0.
REQ-016 A transfer is defined as grant_valid & downstream_ready & request[w], where w is the granted port.
REQ-017 In LOCKED, SHALL hold grant_oh unchanged until a transfer with request_tail[w]=1.
REQ-018 On a tail transfer, SHALL set ptr=(w+1) mod NUM_REQUESTERS, clear grant_oh, and enter IDLE at the next edge.
REQ-019 The guaranteed bubble after release is exactly one cycle; no back-to-back re-grant occurs in the release cycle.
REQ-020 In LOCKED, if request[w] deasserts, SHALL keep the grant; no transfer occurs and no release occurs.
REQ-021 SHALL ignore request_tail[w] while downstream_ready=0.
REQ-022 SHALL ignore request and request_tail bits of non-granted ports entirely.
REQ-023 grant_oh SHALL never have more than one bit set.
REQ-024 grant_valid SHALL equal |grant_oh.
REQ-025 grant_idx SHALL be combinational from grant_oh, and SHALL be 0 when grant_oh=0.
REQ-026 Pointer wrap: after release of port NUM_REQUESTERS-1, ptr SHALL be 0.

Reset
REQ-027 While reset_n=0 at a rising edge, SHALL set state=IDLE, ptr=0, grant_oh=0.
REQ-028 Consequently, during reset grant_valid=0 and grant_idx=0.
REQ-029 Reset mid-packet SHALL abandon the lock without any release bookkeeping; ptr returns to 0.
REQ-030 The first post-reset arbitration SHALL occur in the first cycle with reset_n=1.

Structure
REQ-031 SHALL place the state encoding (IDLE, LOCKED) in the shared NoC package.
REQ-032 SHALL obtain grant_idx from one instance of the existing one-hot-to-index encoder, with NUM_SIGNALS=NUM_REQUESTERS and DIRECTION="LSB0".
REQ-033 SHALL implement the round-robin scan inside this module, using no further sub-modules.

Verification (NUM_REQUESTERS=4)
REQ-034 Reset: hold reset_n=0 with request=4'b1111 -> grant_oh=0, grant_valid=0, grant_idx=0 throughout.
REQ-035 Fairness: request=4'b1111, all tails=1, ready=1 -> grants 0001,0010,0100,1000,0001, each separated by one idle cycle; grant_idx 0,1,2,3,0.
REQ-036 Lock: port 2 sends a 3-flit packet with ready pattern 1,0,1,1 and port 0 also requesting -> grant_oh=0100 for 4 cycles; release only after the tail is accepted, then port 0 is granted.
REQ-037 Tail stall: tail present but ready=0 for 5 cycles -> grant held with no release; release on the first ready=1 cycle.
REQ-038 Wrap: after port 3 releases, request=4'b1001 -> port 0 is granted, not port 3.
REQ-039 Reset mid-packet: reset_n=0 while locked on port 1 -> grant_oh=0 next edge; afterwards request=4'b0011 -> port 0 is granted.
